// File: rtl/rsdec_pkg.sv
// Shared definitions for the Reed-Solomon correction stage.
// Holds the symbol width, default code parameters and the symbol/count types,
// plus a saturating increment used by the error counter.
package rsdec_pkg;

  // GF(2^8) symbols
  localparam int SYM_W     = 8;
  // Default codeword length in symbols
  localparam int N_DEF     = 255;
  // Design correction capability (max correctable symbol errors)
  localparam int T         = 8;
  // Default received-symbol buffer depth (power of two, >= 2*N)
  localparam int DEPTH_DEF = 512;

  typedef logic [SYM_W-1:0] sym_t;
  typedef logic [7:0]       cnt_t;
  typedef logic [3:0]       deg_t;

  // Increment that sticks at the all-ones value instead of wrapping.
  function automatic cnt_t sat_inc(input cnt_t v);
    cnt_t r;
    r = (v == 8'hFF) ? v : v + 8'd1;
    return r;
  endfunction

endpackage

// File: rtl/rsdec_correct_fifo.sv
// Circular buffer holding received symbols until the Chien search reaches them.
// Ports: wr/wr_data push a symbol, rd pops one (rd_data valid combinationally
// while rd_ok), ovf_evt/unf_evt flag a refused push / pop for the sticky flags.
module rsdec_correct_fifo
  import rsdec_pkg::*;
#(
  parameter int DEPTH = DEPTH_DEF
) (
  input  logic clk,
  input  logic clrn,
  input  logic wr,
  input  sym_t wr_data,
  input  logic rd,
  output sym_t rd_data,
  output logic rd_ok,
  output logic ovf_evt,
  output logic unf_evt
);

  localparam int AW = $clog2(DEPTH);

  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [AW:0]   occ;
  logic          full;
  logic          empty;
  logic          wr_ok;

  sym_t mem [DEPTH];

  assign full  = (occ == (AW+1)'(DEPTH));
  assign empty = (occ == '0);

  // A pop never depends on the push in the same cycle, so an empty buffer
  // refuses the pop even if a symbol is arriving.
  assign rd_ok = rd && !empty;

  // A full buffer still takes a push when a pop frees a slot in the same
  // cycle; the slot being overwritten is the one read out this cycle, and
  // the read below sees the old contents because the write lands at the edge.
  assign wr_ok = wr && (!full || rd_ok);

  assign ovf_evt = wr && !wr_ok;
  assign unf_evt = rd && empty;

  assign rd_data = mem[rd_ptr];

  // Storage carries no reset: clearing the pointers is enough to discard it.
  always_ff @(posedge clk) begin
    if (wr_ok) begin
      mem[wr_ptr] <= wr_data;
    end
  end

  // DEPTH is a power of two, so the pointers wrap DEPTH-1 -> 0 naturally.
  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      occ    <= '0;
    end else begin
      if (wr_ok) begin
        wr_ptr <= wr_ptr + AW'(1);
      end
      if (rd_ok) begin
        rd_ptr <= rd_ptr + AW'(1);
      end
      case ({wr_ok, rd_ok})
        2'b10:   occ <= occ + (AW+1)'(1);
        2'b01:   occ <= occ - (AW+1)'(1);
        default: occ <= occ;
      endcase
    end
  end

endmodule

// File: rtl/rsdec_correct.sv
// Reed-Solomon correction stage: buffers received symbols and XORs each with
// the Chien-search error magnitude, counting errors and flagging decode failure.
// Ports: in_valid/in_data feed the buffer; search/error/deg come from the
// Chien search; out_valid/out_data/out_last carry corrected symbols one cycle
// after each accepted search cycle (no backpressure); err_cnt/fail are
// reported with out_last; ovf/unf are sticky buffer-misuse flags.
module rsdec_correct
  import rsdec_pkg::*;
#(
  parameter int N     = N_DEF,
  parameter int DEPTH = DEPTH_DEF
) (
  input  logic       clk,
  input  logic       clrn,
  input  logic       in_valid,
  input  logic [7:0] in_data,
  input  logic       search,
  input  logic [7:0] error,
  input  logic [3:0] deg,
  output logic       out_valid,
  output logic [7:0] out_data,
  output logic       out_last,
  output logic [7:0] err_cnt,
  output logic       fail,
  output logic       ovf,
  output logic       unf
);

  sym_t rd_sym;
  logic rd_ok;
  logic ovf_evt;
  logic unf_evt;

  rsdec_correct_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk     (clk),
    .clrn    (clrn),
    .wr      (in_valid),
    .wr_data (in_data),
    .rd      (search),
    .rd_data (rd_sym),
    .rd_ok   (rd_ok),
    .ovf_evt (ovf_evt),
    .unf_evt (unf_evt)
  );

  // Position of the next symbol to come out of the search within its codeword.
  logic [7:0] sym_cnt;
  // Running error count for the codeword in progress.
  cnt_t       run_cnt;
  // Locator degree captured at the first symbol of the codeword.
  deg_t       deg_q;

  logic       first_sym;
  logic       last_sym;
  deg_t       deg_eff;
  cnt_t       run_base;
  cnt_t       run_next;

  always_comb begin
    first_sym = (sym_cnt == 8'd0);
    last_sym  = (sym_cnt == 8'(N-1));
    // On the first symbol the live deg input is the one that applies, and
    // the count restarts from zero so that symbol's own error is included.
    deg_eff   = first_sym ? deg : deg_q;
    run_base  = first_sym ? '0 : run_cnt;
    run_next  = (error != 8'h00) ? sat_inc(run_base) : run_base;
  end

  // Codeword bookkeeping advances only on accepted search cycles, so a
  // paused or starved search leaves everything where it was.
  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      sym_cnt <= '0;
      run_cnt <= '0;
      deg_q   <= '0;
    end else if (rd_ok) begin
      sym_cnt <= last_sym ? 8'd0 : sym_cnt + 8'd1;
      run_cnt <= run_next;
      if (first_sym) begin
        deg_q <= deg;
      end
    end
  end

  // Output stage. out_data keeps its last value between valid cycles;
  // err_cnt/fail update only with the final symbol of a codeword.
  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_last  <= 1'b0;
      err_cnt   <= '0;
      fail      <= 1'b0;
    end else begin
      out_valid <= rd_ok;
      out_last  <= rd_ok && last_sym;
      if (rd_ok) begin
        out_data <= rd_sym ^ error;
        if (last_sym) begin
          err_cnt <= run_next;
          fail    <= (run_next != {4'b0000, deg_eff});
        end
      end
    end
  end

  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      ovf <= 1'b0;
      unf <= 1'b0;
    end else begin
      if (ovf_evt) begin
        ovf <= 1'b1;
      end
      if (unf_evt) begin
        unf <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_rsdec_correct.sv
// Directed self-checking bench for rsdec_correct (N=255, DEPTH=512).
// Inputs change 1 time unit after the rising edge; outputs are sampled there too.
// Expected values come from the written sequence and the injected error table.
module tb_rsdec_correct;

  localparam int NS = 255;

  logic       clk = 1'b0;
  logic       clrn;
  logic       in_valid;
  logic [7:0] in_data;
  logic       search;
  logic [7:0] error;
  logic [3:0] deg;
  logic       out_valid;
  logic [7:0] out_data;
  logic       out_last;
  logic [7:0] err_cnt;
  logic       fail;
  logic       ovf;
  logic       unf;

  int tests  = 0;
  int failed = 0;

  logic [7:0] errs [0:NS-1];
  logic [7:0] obs  [0:NS-1];
  logic [7:0] last_out;

  always #5 clk = ~clk;

  rsdec_correct #(
    .N     (255),
    .DEPTH (512)
  ) dut (
    .clk       (clk),
    .clrn      (clrn),
    .in_valid  (in_valid),
    .in_data   (in_data),
    .search    (search),
    .error     (error),
    .deg       (deg),
    .out_valid (out_valid),
    .out_data  (out_data),
    .out_last  (out_last),
    .err_cnt   (err_cnt),
    .fail      (fail),
    .ovf       (ovf),
    .unf       (unf)
  );

  task automatic chk(input string tag, input logic [31:0] o, input logic [31:0] e);
    tests++;
    assert (o === e) else begin
      failed++;
      $error("FAIL %s: observed %0h, expected %0h", tag, o, e);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check_zero(input string tag);
    chk({tag, "_out_valid"}, out_valid, 0);
    chk({tag, "_out_data"},  out_data,  0);
    chk({tag, "_out_last"},  out_last,  0);
    chk({tag, "_err_cnt"},   err_cnt,   0);
    chk({tag, "_fail"},      fail,      0);
    chk({tag, "_ovf"},       ovf,       0);
    chk({tag, "_unf"},       unf,       0);
  endtask

  task automatic pulse_reset(input string tag);
    clrn = 1'b0;
    #2;
    check_zero(tag);
    @(posedge clk);
    #1;
    clrn = 1'b1;
    step();
    check_zero({tag, "_post"});
  endtask

  task automatic clear_errs();
    for (int i = 0; i < NS; i++) errs[i] = 8'h00;
  endtask

  task automatic write_syms(input int n);
    for (int i = 0; i < n; i++) begin
      in_valid = 1'b1;
      in_data  = 8'(i);
      step();
    end
    in_valid = 1'b0;
  endtask

  // Runs n search cycles on a codeword whose symbol i was written as i.
  task automatic run_search(input int n, input logic [3:0] d, input int pause_at,
                            input bit check_end, input logic [7:0] exp_cnt,
                            input logic exp_fail);
    for (int i = 0; i < n; i++) begin
      if (i == pause_at) begin
        search = 1'b0;
        error  = 8'hAA;
        deg    = 4'hF;
        for (int p = 0; p < 3; p++) begin
          step();
          chk("pause_out_valid", out_valid, 0);
          chk("pause_out_data_hold", out_data, last_out);
        end
      end
      search = 1'b1;
      error  = errs[i];
      deg    = d;
      step();
      chk("out_valid", out_valid, 1);
      chk("out_data", out_data, 8'(i) ^ errs[i]);
      chk("out_last", out_last, (i == NS-1));
      obs[i]   = out_data;
      last_out = out_data;
    end
    search = 1'b0;
    error  = 8'h00;
    if (check_end) begin
      chk("err_cnt", err_cnt, exp_cnt);
      chk("fail", fail, exp_fail);
    end
  endtask

  initial begin
    clrn     = 1'b1;
    in_valid = 1'b0;
    in_data  = 8'h00;
    search   = 1'b0;
    error    = 8'h00;
    deg      = 4'h0;
    last_out = 8'h00;
    clear_errs();

    // Reset state
    #2 clrn = 1'b0;
    #10;
    check_zero("reset");
    @(posedge clk);
    #1;
    clrn = 1'b1;
    step();

    // Clean codeword: data passes through, no errors, deg 0
    write_syms(NS);
    clear_errs();
    run_search(NS, 4'd0, -1, 1'b1, 8'd0, 1'b0);

    // Search on empty buffer: no output, unf set, counter stays at symbol 0
    search = 1'b1;
    error  = 8'h33;
    step();
    chk("unf_out_valid", out_valid, 0);
    chk("unf_flag", unf, 1);
    chk("unf_out_last", out_last, 0);
    chk("unf_out_data_hold", out_data, 8'hFE);
    chk("unf_no_ovf", ovf, 0);
    search = 1'b0;
    error  = 8'h00;
    step();

    // Two errors of 0x5A at symbols 3 and 100, deg 2
    write_syms(NS);
    clear_errs();
    errs[3]   = 8'h5A;
    errs[100] = 8'h5A;
    run_search(NS, 4'd2, -1, 1'b1, 8'd2, 1'b0);
    chk("sym3_corrected", obs[3], 8'h59);
    chk("sym100_corrected", obs[100], 8'h3E);

    // Two errors but deg 3: failure
    write_syms(NS);
    clear_errs();
    errs[10] = 8'h01;
    errs[20] = 8'hFF;
    run_search(NS, 4'd3, -1, 1'b1, 8'd2, 1'b1);
    repeat (4) step();
    chk("hold_err_cnt", err_cnt, 2);
    chk("hold_fail", fail, 1);
    chk("hold_out_valid", out_valid, 0);
    chk("hold_out_data", out_data, 8'hFE);

    // Overflow: 513 writes into a 512-deep buffer
    for (int i = 0; i < 513; i++) begin
      in_valid = 1'b1;
      in_data  = 8'(i);
      if (i == 512) chk("ovf_before_full_write", ovf, 0);
      step();
    end
    in_valid = 1'b0;
    chk("ovf_set", ovf, 1);
    search = 1'b1;
    error  = 8'h00;
    deg    = 4'd0;
    step();
    chk("ovf_rd0_valid", out_valid, 1);
    chk("ovf_rd0_data", out_data, 8'h00);
    step();
    chk("ovf_rd1_valid", out_valid, 1);
    chk("ovf_rd1_data", out_data, 8'h01);
    chk("ovf_rd1_last", out_last, 0);
    search = 1'b0;

    // Reset clears sticky flags and discards the full buffer
    pulse_reset("rst2");

    // Reset after 100 search cycles of a codeword
    write_syms(NS);
    clear_errs();
    run_search(100, 4'd0, -1, 1'b0, 8'd0, 1'b0);
    pulse_reset("rst_mid");

    // Fresh codeword after reset, errors at first and last symbol, with a pause
    write_syms(NS);
    clear_errs();
    errs[0]    = 8'h11;
    errs[NS-1] = 8'h80;
    run_search(NS, 4'd2, 50, 1'b1, 8'd2, 1'b0);
    chk("final_sym0", obs[0], 8'h11);
    chk("final_sym254", obs[NS-1], 8'h7E);

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule

// File: doc/rsdec_correct.md
RSDEC_CORRECT -- requirements
Module: rsdec_correct

Interface
REQ-001 Parameter N, 255, codeword length in symbols (3..255).
REQ-002 Parameter DEPTH, 512, received-symbol buffer depth (power of two, >= 2*N).
REQ-003 clk  input  1  single clock; all state changes on rising edge.
REQ-004 clrn  input  1  reset; asynchronous, active-low.
REQ-005 in_valid  input  1  received symbol present on in_data this cycle.
REQ-006 in_data  input  8  received symbol, first symbol of codeword first.
REQ-007 search  input  1  Chien search active; one error symbol per cycle, same order as in_data.
REQ-008 error  input  8  error magnitude from Chien search (0 = no error).
REQ-009 deg  input  4  error-locator degree; sampled on first search cycle of each codeword.
REQ-010 out_valid  output  1  corrected symbol present on out_data.
REQ-011 out_data  output  8  corrected symbol = buffered symbol XOR error.
REQ-012 out_last  output  1  marks final (N-th) corrected symbol of a codeword.
REQ-013 err_cnt  output  8  count of nonzero error symbols; valid with out_last.
REQ-014 fail  output  1  decode failure; valid with out_last.
REQ-015 ovf  output  1  sticky: write attempted while buffer full.
REQ-016 unf  output  1  sticky: search asserted while buffer empty.

Function
REQ-017 Buffer: circular, write pointer and read pointer each log2(DEPTH) bits, wrap at DEPTH-1 -> 0; occupancy counter log2(DEPTH)+1 bits.
REQ-018 in_valid with buffer not full: store in_data, advance write pointer, occupancy +1.
REQ-019 in_valid with buffer full: drop symbol, pointers unchanged, set ovf.
REQ-020 search with buffer not empty: read symbol, advance read pointer, occupancy -1.
REQ-021 search with buffer empty: no read, no output, set unf; symbol counter does not advance.
REQ-022 Simultaneous write and read: both performed, occupancy unchanged; write into full buffer with simultaneous read is accepted.
REQ-023 Latency: out_valid/out_data/out_last registered, exactly 1 cycle after the accepted search cycle; no backpressure.
REQ-024 Symbol counter 0..N-1 advances on each accepted search cycle, wraps N-1 -> 0; out_last asserted for the output of count N-1.
REQ-025 Count 0 cycle: capture deg, restart error count (first error of new codeword counts).
REQ-026 Error counter increments for each accepted cycle with error != 0, saturates at 255.
REQ-027 At out_last: err_cnt = final count; fail = 1 if count != captured deg, else 0.
REQ-028 err_cnt and fail hold their values until next out_last; out_data holds when out_valid = 0.
REQ-029 search deasserted mid-codeword: counters hold; resume on next search cycle.

Reset
REQ-030 clrn low: pointers, occupancy, symbol counter, error counter, captured deg = 0; out_valid, out_last, fail, ovf, unf = 0; out_data, err_cnt = 0.
REQ-031 Reset mid-codeword discards buffer contents and partial count; first symbol after release is symbol 0 of a new codeword.
REQ-032 ovf/unf clear only by reset.

Structure
REQ-033 Shared package rsdec_pkg holds symbol width (8), default N (255), T (8), and the symbol typedef.
REQ-034 Buffer memory plus pointers/occupancy as one sub-module rsdec_correct_fifo; counting, compare, and output stage in top.

Verification
REQ-035 N=255, write 255 symbols 0x00..0xFE, then search 255 cycles with error=0 and deg=0 -> out_data = input sequence, out_last on 255th output, err_cnt=0, fail=0.
REQ-036 Same codeword, error=0x5A at symbols 3 and 100, deg=2 -> out_data[3]=0x03^0x5A=0x59, out_data[100]=0x64^0x5A=0x3E, err_cnt=2, fail=0.
REQ-037 Two errors injected, deg=3 -> err_cnt=2, fail=1 at out_last.
REQ-038 DEPTH=512: write 513 symbols with no search -> 513th dropped, ovf=1; then a 2-cycle search returns symbols 0 and 1.
REQ-039 search asserted with empty buffer -> unf=1, out_valid stays 0, symbol counter unchanged.
REQ-040 clrn pulsed after 100 search cycles -> all outputs 0; next codeword of 255 symbols corrects normally with out_last on its 255th output.
